// File: rtl/button_debouncer_pkg.sv
// rtl/button_debouncer_pkg.sv - shared helpers for the button debouncer
package button_debouncer_pkg;

    // Map a synchronised pin level onto "1 = pressed"
    function automatic logic normalise_level(input logic pin_level, input bit active_low);
        return active_low ? ~pin_level : pin_level;
    endfunction

    // Raw pin level that corresponds to a released button
    function automatic logic released_pin_level(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// rtl/button_debouncer_channel.sv - synchroniser, debounce, strobes and hold for one input
module button_debouncer_channel
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int HOLD_CYCLES     = 16777216,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_state,
    output logic btn_press,
    output logic btn_release,
    output logic btn_hold
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ARM  = HW'(HOLD_CYCLES - 2);
    localparam logic PIN_RELEASED = released_pin_level(ACTIVE_LOW);

    logic          sync_q1;
    logic          sync_q2;
    logic          level;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt;
    logic          accept;

    // Two-flop synchroniser; reset to the released pin level so reset exit looks idle
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= PIN_RELEASED;
            sync_q2 <= PIN_RELEASED;
        end else begin
            sync_q1 <= btn_in;
            sync_q2 <= sync_q1;
        end
    end

    assign level  = normalise_level(sync_q2, ACTIVE_LOW);
    assign accept = (level != btn_state) && (deb_cnt == DEB_LAST);

    // Debounce: count consecutive differing cycles, any agreeing cycle restarts the count
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt     <= '0;
            btn_state   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            if (level == btn_state) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt     <= '0;
                btn_state   <= level;
                btn_press   <= level;
                btn_release <= ~level;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Long-hold: saturating count while pressed; cleared together with the release strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            btn_hold <= 1'b0;
        end else if (accept && !level) begin
            hold_cnt <= '0;
            btn_hold <= 1'b0;
        end else if (btn_state) begin
            if (hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_cnt == HOLD_ARM) begin
                    btn_hold <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - multi-channel push-button debouncer with press/release/hold outputs
module button_debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int HOLD_CYCLES     = 16777216,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] btn_state,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release,
    output logic [WIDTH-1:0] btn_hold
);

    // Channels share nothing but the clock and reset
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        button_debouncer_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .btn_in      (btn_in[i]),
            .btn_state   (btn_state[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_hold    (btn_hold[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - randomized self-checking bench against a behavioural model
module tb_button_debouncer;

    localparam int W = 4;
    localparam int D = 8;
    localparam int H = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pin_al;
    logic [W-1:0] pin_ah;
    logic [W-1:0] st_al, pr_al, rl_al, hd_al;
    logic [W-1:0] st_ah, pr_ah, rl_ah, hd_ah;

    always #5 clk = ~clk;

    button_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .ACTIVE_LOW(1'b1)) u_al (
        .clk(clk), .rst(rst), .btn_in(pin_al),
        .btn_state(st_al), .btn_press(pr_al), .btn_release(rl_al), .btn_hold(hd_al)
    );

    button_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .ACTIVE_LOW(1'b0)) u_ah (
        .clk(clk), .rst(rst), .btn_in(pin_ah),
        .btn_state(st_ah), .btn_press(pr_ah), .btn_release(rl_ah), .btn_hold(hd_ah)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: a change is accepted once the pressed level seen by the
    // debouncer has disagreed with the accepted level for D consecutive edges.
    logic [W-1:0] m_p1, m_p2, m_state, m_press, m_rel, m_hold;
    int           m_since [W];
    int           m_held  [W];
    logic         m_hist  [W][$];

    task automatic model_edge(input logic [W-1:0] pressed, input logic r);
        logic [W-1:0] s;
        bit ok;
        if (r) begin
            m_p1 = '0; m_p2 = '0; m_state = '0;
            m_press = '0; m_rel = '0; m_hold = '0;
            for (int c = 0; c < W; c++) begin
                m_since[c] = 0;
                m_held[c]  = 0;
                m_hist[c].delete();
            end
        end else begin
            s    = m_p2;
            m_p2 = m_p1;
            m_p1 = pressed;
            for (int c = 0; c < W; c++) begin
                m_press[c] = 1'b0;
                m_rel[c]   = 1'b0;
                m_hist[c].push_back(s[c]);
                if (m_hist[c].size() > D) void'(m_hist[c].pop_front());
                m_since[c]++;
                ok = (m_since[c] >= D);
                foreach (m_hist[c][j]) if (m_hist[c][j] == m_state[c]) ok = 0;
                if (ok) begin
                    m_since[c] = 0;
                    m_held[c]  = 0;
                    if (s[c]) begin
                        m_state[c] = 1'b1;
                        m_press[c] = 1'b1;
                    end else begin
                        m_state[c] = 1'b0;
                        m_rel[c]   = 1'b1;
                        m_hold[c]  = 1'b0;
                    end
                end else if (m_state[c]) begin
                    if (m_held[c] < H - 1) m_held[c]++;
                    m_hold[c] = (m_held[c] >= H - 1);
                end
            end
        end
    endtask

    task automatic step(input logic [W-1:0] pressed, input logic r);
        pin_ah = pressed;
        pin_al = ~pressed;
        rst    = r;
        @(posedge clk);
        model_edge(pressed, r);
        #1;
        chk("state_al",   st_al, m_state);
        chk("press_al",   pr_al, m_press);
        chk("release_al", rl_al, m_rel);
        chk("hold_al",    hd_al, m_hold);
        chk("state_ah",   st_ah, m_state);
        chk("press_ah",   pr_ah, m_press);
        chk("release_ah", rl_ah, m_rel);
        chk("hold_ah",    hd_ah, m_hold);
    endtask

    logic [W-1:0] cur;
    int           n;
    int           dur [W];

    initial begin
        cur = '0;
        step(cur, 1'b1);
        step(cur, 1'b1);
        chk("reset_state", {st_al, pr_al, rl_al, hd_al}, 16'h0);
        repeat (3) step(cur, 1'b0);

        // Clean press on channel 0
        cur[0] = 1'b1;
        step(cur, 1'b0);
        n = 0;
        do begin step(cur, 1'b0); n++; end while (!pr_al[0] && n <= 40);
        chk("press_latency", n, 9);
        chk("press_others", pr_al[W-1:1], 3'b000);
        step(cur, 1'b0);
        chk("press_one_cycle", pr_al[0], 1'b0);

        // Bounce on channel 1, then a clean press
        for (int k = 0; k < 2; k++) begin
            cur[1] = 1'b1; repeat (5) step(cur, 1'b0);
            cur[1] = 1'b0; step(cur, 1'b0);
        end
        repeat (3) step(cur, 1'b0);
        chk("bounce_rejected", st_al[1], 1'b0);
        cur[1] = 1'b1;
        step(cur, 1'b0);
        n = 0;
        do begin step(cur, 1'b0); n++; end while (!pr_al[1] && n <= 40);
        chk("bounce_press_latency", n, 9);

        // Long hold on channel 0, then clean release
        repeat (40) step(cur, 1'b0);
        chk("hold_set", hd_al[0], 1'b1);
        cur[0] = 1'b0;
        step(cur, 1'b0);
        n = 0;
        do begin step(cur, 1'b0); n++; end while (!rl_al[0] && n <= 40);
        chk("release_latency", n, 9);
        chk("hold_drop_with_release", hd_al[0], 1'b0);

        // All channels together
        cur = '0;
        repeat (12) step(cur, 1'b0);
        cur = '1;
        step(cur, 1'b0);
        n = 0;
        do begin step(cur, 1'b0); n++; end while (pr_al == '0 && n <= 40);
        chk("press_all", pr_al, 4'hF);
        chk("state_all", st_al, 4'hF);

        // Reset while holding and while channel 3 is mid-count
        repeat (40) step(cur, 1'b0);
        cur[3] = 1'b0;
        repeat (4) step(cur, 1'b0);
        step(cur, 1'b1);
        chk("reset_clears", {st_al, pr_al, rl_al, hd_al}, 16'h0);
        n = 0;
        do begin step(cur, 1'b0); n++; end while (pr_al == '0 && n <= 40);
        chk("repress_after_reset", n, 10);
        chk("repress_channels", pr_al, 4'h7);

        // Randomized stretches of bouncing and stable levels
        for (int c = 0; c < W; c++) dur[c] = 1;
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < W; c++) begin
                dur[c]--;
                if (dur[c] <= 0) begin
                    cur[c] = ~cur[c];
                    dur[c] = ($urandom_range(0, 9) < 6) ? int'($urandom_range(1, 9))
                                                        : int'($urandom_range(10, 60));
                end
            end
            step(cur, ($urandom_range(0, 399) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
